// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : puf_ctrl_pkg
// Purpose  : Shared constants for the ring-oscillator PUF measurement
//            sequencer: default parameter values, FSM state encoding,
//            tie counter width and small elaboration-time helpers.
// Revision : 1.0 - initial release
// ============================================================================
package puf_ctrl_pkg;

    // Default parameter values for the sequencer
    localparam int c_DEF_SEL_W         = 5;
    localparam int c_DEF_CNT_W         = 8;
    localparam int c_DEF_RESP_BITS     = 8;
    localparam int c_DEF_CLR_CYCLES    = 2;
    localparam int c_DEF_WINDOW_CYCLES = 256;
    localparam int c_DEF_SETTLE_CYCLES = 4;

    // Width of the saturating tie counter
    localparam int c_TIE_W = 4;

    // Sequencer state encoding
    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_CLEAR  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_RUN    = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_SETTLE = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_SAMPLE = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_DONE   = 3'd5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The phase timer is loaded with (cycles-1), so clog2(cycles) bits suffice.
    function automatic int timer_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : puf_phase_timer
// Purpose  : Loadable down-counter shared by the CLEAR, RUN and SETTLE
//            phases. Loading value N-1 makes o_done rise in the N-th cycle
//            after the load edge.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_load          - load i_load_val on the next edge
//            i_load_val      - phase length minus one
//            o_done          - count has reached zero
// Revision : 1.0 - initial release
// ============================================================================
module puf_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/puf_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : puf_measure_ctrl
// Purpose  : Ring-oscillator PUF measurement sequencer. For each response
//            bit it selects challenge+idx on both oscillator banks, clears
//            the counters, opens a timed enable window, lets the counters
//            settle, then compares the two counts into the response word.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            i_start          - begin a measurement (accepted only in IDLE)
//            i_abort          - cancel; back to IDLE without valid
//            i_challenge      - base challenge, latched on accepted start
//            i_cnt_a/i_cnt_b  - frozen bank counter values
//            o_osc_en         - oscillator enable to both banks
//            o_cnt_clr        - counter clear, active high
//            o_sel            - oscillator select to both banks
//            o_busy           - measurement in progress (through DONE)
//            o_valid          - one-cycle pulse, response complete
//            o_response       - response word, held until next start
//            o_tie_cnt        - saturating count of equal-count samples
// Revision : 1.0 - initial release
// ============================================================================
module puf_measure_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int SEL_W         = c_DEF_SEL_W,
    parameter int CNT_W         = c_DEF_CNT_W,
    parameter int RESP_BITS     = c_DEF_RESP_BITS,
    parameter int CLR_CYCLES    = c_DEF_CLR_CYCLES,
    parameter int WINDOW_CYCLES = c_DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = c_DEF_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [SEL_W-1:0]     i_challenge,
    input  logic [CNT_W-1:0]     i_cnt_a,
    input  logic [CNT_W-1:0]     i_cnt_b,
    output logic                 o_osc_en,
    output logic                 o_cnt_clr,
    output logic [SEL_W-1:0]     o_sel,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [RESP_BITS-1:0] o_response,
    output logic [c_TIE_W-1:0]   o_tie_cnt
);

    localparam int c_IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int c_TMR_W = timer_width(max3(CLR_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES));
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(RESP_BITS - 1);
    localparam logic [c_TIE_W-1:0] c_TIE_MAX  = '1;

    logic [c_ST_W-1:0]    r_state;
    logic [c_ST_W-1:0]    w_state_nxt;
    logic [SEL_W-1:0]     r_chal;
    logic [SEL_W-1:0]     r_sel;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_inc;
    logic [RESP_BITS-1:0] r_resp;
    logic [c_TIE_W-1:0]   r_tie;
    logic                 r_osc_en;
    logic                 r_cnt_clr;
    logic                 r_busy;
    logic                 r_valid;
    logic                 w_accept;
    logic                 w_sample;
    logic                 w_tmr_done;
    logic                 w_tmr_load;
    logic [c_TMR_W-1:0]   w_tmr_val;

    // abort beats start in IDLE, and beats the sample write in SAMPLE
    assign w_accept  = (r_state == c_ST_IDLE) && i_start && !i_abort;
    assign w_sample  = (r_state == c_ST_SAMPLE) && !i_abort;
    assign w_idx_inc = r_idx + c_IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept)   w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR:  if (w_tmr_done) w_state_nxt = c_ST_RUN;
            c_ST_RUN:    if (w_tmr_done) w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE: if (w_tmr_done) w_state_nxt = c_ST_SAMPLE;
            c_ST_SAMPLE: w_state_nxt = (r_idx == c_LAST_IDX) ? c_ST_DONE : c_ST_CLEAR;
            c_ST_DONE:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Every state change reloads the timer; only the timed phases care
    // about the value, the others simply load zero.
    always_comb begin
        w_tmr_load = (w_state_nxt != r_state);
        case (w_state_nxt)
            c_ST_CLEAR:  w_tmr_val = c_TMR_W'(CLR_CYCLES - 1);
            c_ST_RUN:    w_tmr_val = c_TMR_W'(WINDOW_CYCLES - 1);
            c_ST_SETTLE: w_tmr_val = c_TMR_W'(SETTLE_CYCLES - 1);
            default:     w_tmr_val = '0;
        endcase
    end

    puf_phase_timer #(
        .WIDTH      (c_TMR_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_chal    <= '0;
            r_sel     <= '0;
            r_idx     <= '0;
            r_resp    <= '0;
            r_tie     <= '0;
            r_osc_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_osc_en  <= (w_state_nxt == c_ST_RUN);
            r_cnt_clr <= (w_state_nxt == c_ST_CLEAR);
            r_busy    <= (w_state_nxt != c_ST_IDLE);
            r_valid   <= (w_state_nxt == c_ST_DONE);

            if (w_accept) begin
                r_chal <= i_challenge;
                r_sel  <= i_challenge;
                r_idx  <= '0;
                r_resp <= '0;
                r_tie  <= '0;
            end

            if (w_sample) begin
                r_resp[r_idx] <= (i_cnt_a > i_cnt_b);
                if ((i_cnt_a == i_cnt_b) && (r_tie != c_TIE_MAX)) begin
                    r_tie <= r_tie + c_TIE_W'(1);
                end
                if (r_idx != c_LAST_IDX) begin
                    r_idx <= w_idx_inc;
                    // select wraps modulo 2^SEL_W by truncation
                    r_sel <= r_chal + SEL_W'(w_idx_inc);
                end
            end
        end
    end

    assign o_osc_en   = r_osc_en;
    assign o_cnt_clr  = r_cnt_clr;
    assign o_sel      = r_sel;
    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_response = r_resp;
    assign o_tie_cnt  = r_tie;

endmodule
`default_nettype wire

// File: doc/puf_measure_ctrl.md
Name: puf_measure_ctrl

Overview:
Sequencer for the ring-oscillator PUF datapath. It drives one challenge at a time onto the two oscillator banks through their shared select lines, and clears the ripple counters. It then opens a timed enable window, freezes the oscillators, compares the two frozen counts, and shifts one response bit per challenge into an N-bit response register. It sits between the host I/O pins and the oscillator banks, counters and comparator, and replaces direct pin control of enable and reset.

Parameters:
SEL_W, 5, width of oscillator select/challenge
CNT_W, 8, width of each oscillator counter
RESP_BITS, 8, response bits produced per start
CLR_CYCLES, 2, clk cycles counter clear is asserted
WINDOW_CYCLES, 256, clk cycles oscillators are enabled per bit
SETTLE_CYCLES, 4, clk cycles after disable before sampling counts

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin measurement; honoured only in IDLE
abort  in  1  cancel measurement; return to IDLE, no valid
challenge  in  SEL_W  base challenge, latched on accepted start
cnt_a  in  CNT_W  bank A counter value (stable when osc_en=0)
cnt_b  in  CNT_W  bank B counter value
osc_en  out  1  oscillator enable to both banks
cnt_clr  out  1  counter clear, active high
sel  out  SEL_W  oscillator select to both banks
busy  out  1  high from the cycle after accepted start through DONE
valid  out  1  one-cycle pulse: response complete
response  out  RESP_BITS  response word, held until the next accepted start
tie_cnt  out  4  saturating count of cnt_a==cnt_b events in the last run

Behaviour:
- Clock is clk. Reset is asynchronous, active-low (rst_n).
- All outputs are registered. Reset values: osc_en=0, cnt_clr=0, sel=0, busy=0, valid=0, response=0, tie_cnt=0, state=IDLE, bit index=0.
- States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE.
- IDLE: start=1 latches challenge, clears response, bit index and tie_cnt, then goes to CLEAR. start is ignored in every other state.
- CLEAR: cnt_clr=1, osc_en=0, sel=challenge+idx (mod 2^SEL_W). Lasts CLR_CYCLES cycles, then RUN.
- RUN: osc_en=1, cnt_clr=0, sel held. Lasts WINDOW_CYCLES cycles, then SETTLE.
- SETTLE: osc_en=0. Lasts SETTLE_CYCLES cycles so ripple counters go quiet before sampling, then SAMPLE.
- SAMPLE (1 cycle): response[idx] = (cnt_a > cnt_b), unsigned compare; a tie gives 0 and increments tie_cnt, saturating at 15.
  - idx==RESP_BITS-1 -> DONE.
  - Otherwise idx++ -> CLEAR.
- DONE (1 cycle): valid=1, busy=0 on exit, then IDLE.
- Per-bit latency = CLR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+1.
- Total latency from start edge to valid = RESP_BITS × per-bit latency + 1.
- abort: in any non-IDLE state, next cycle is IDLE with osc_en=0, cnt_clr=0, busy=0 and no valid pulse. response keeps partially written bits. abort has priority over start and over state timers.
- Reset mid-operation drops osc_en immediately (asynchronous) and forces IDLE.
- start and abort in the same IDLE cycle: abort wins and start is dropped.
- sel wrap: challenge 31 with idx 1 gives sel=0.
- Counter wrap within a window is not detected. WINDOW_CYCLES is sized by integration.

Decomposition:
- Package puf_ctrl_pkg holds the state enum, default parameter constants, and the tie_cnt width.
- Sub-module puf_phase_timer: loadable down-counter with a done flag, sized for max(CLR, WINDOW, SETTLE). It is reused for all three timed phases.

Test Plan:
Bench parameters: WINDOW=8, SETTLE=2, CLR=2, RESP_BITS=4; per-bit latency 13.

- Reset then idle: all outputs 0, and start=0 for 20 cycles keeps busy=0 and valid=0.
- start with challenge=5, model returns cnt_a>cnt_b for bits 0 and 2 only:
  - sel sequence is 5, 6, 7, 8.
  - cnt_clr is high for cycles 1-2 of each bit; osc_en is high for 8 cycles per bit.
  - valid pulses at cycle 53 with response=4'b0101 and tie_cnt=0.
- challenge=31: sel sequence is 31, 0, 1, 2. Counts equal on every bit gives response=0 and tie_cnt=4.
- abort in RUN of bit 2: IDLE next cycle, osc_en=0, no valid pulse, response[1:0] keeps sampled values.
- start pulsed while busy: ignored, with no restart and sel unchanged. A start after DONE is accepted normally.
- rst_n asserted mid-RUN: osc_en=0 and busy=0 immediately without a clk edge, and all outputs return to reset values.
